// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//   Control-flow sequencer for the RV32I branch/jump path. Takes one decoded
//   control-flow instruction at a time, evaluates the branch condition, forms
//   the target, offers a redirect to fetch over valid/ready and then holds a
//   fixed-length pipeline flush. A taken target with bit 1 set raises a
//   misaligned-target exception instead of redirecting.
//
// Parameters
//   FLUSH_CYCLES     cycles flush_o is held after an accepted redirect (0..15)
//
// Ports
//   clk_i            clock, all state on rising edge
//   rst_i            synchronous active-high reset
//   in_valid_i       control-flow instruction presented
//   in_ready_o       block can accept (IDLE only)
//   cf_op_i          00 NOP, 01 BRANCH, 10 JAL, 11 JALR
//   funct3_i         branch condition (BRANCH only)
//   pc_i, rs1_i, rs2_i, imm_i   instruction PC, operands, sign-extended imm
//   base_sel_o       1 = target base is PC, 0 = base is rs1 (JALR)
//   redirect_valid_o new fetch PC offered
//   redirect_ready_i fetch accepts the redirect
//   redirect_pc_o    redirect target
//   link_valid_o     one-cycle strobe to write link_data_o to rd
//   link_data_o      latched pc + 4
//   flush_o          squash younger pipeline stages
//   misalign_exc_o   one-cycle strobe for a misaligned taken target
//   exc_pc_o         PC of the faulting instruction
//
// States
//   IDLE     | waiting for an instruction, in_ready_o high
//   EVAL     | one cycle: condition, target, link/exception strobes
//   REDIRECT | redirect_valid_o high until fetch takes it
//   FLUSH    | flush_o high, counter runs down to 1
// -----------------------------------------------------------------------------
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  cf_op_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    output logic        base_sel_o,
    output logic        redirect_valid_o,
    input  logic        redirect_ready_i,
    output logic [31:0] redirect_pc_o,
    output logic        link_valid_o,
    output logic [31:0] link_data_o,
    output logic        flush_o,
    output logic        misalign_exc_o,
    output logic [31:0] exc_pc_o
);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JAL    = 2'b10;
    localparam logic [1:0] OP_JALR   = 2'b11;

    localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t      state_q;
    logic        in_ready_q;
    logic        redirect_valid_q;
    logic        flush_q;
    logic        base_sel_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] link_data_q;
    logic [31:0] exc_pc_q;
    logic [3:0]  cnt_q;

    logic [1:0]  cf_op_q;
    logic [2:0]  funct3_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;

    logic [31:0] base_d;
    logic [31:0] target_d;
    logic        taken_d;
    logic        misalign_d;
    logic        is_jump_d;

    // Evaluation from the latched operands; only consumed in EVAL.
    always_comb begin
        base_d   = base_sel_q ? pc_q : rs1_q;
        target_d = base_d + imm_q;
        if (cf_op_q == OP_JALR) begin
            target_d[0] = 1'b0;
        end

        taken_d = 1'b0;
        case (cf_op_q)
            OP_NOP:    taken_d = 1'b0;
            OP_JAL,
            OP_JALR:   taken_d = 1'b1;
            OP_BRANCH: begin
                case (funct3_q)
                    3'b000:  taken_d = (rs1_q == rs2_q);
                    3'b001:  taken_d = (rs1_q != rs2_q);
                    3'b100:  taken_d = ($signed(rs1_q) <  $signed(rs2_q));
                    3'b101:  taken_d = ($signed(rs1_q) >= $signed(rs2_q));
                    3'b110:  taken_d = (rs1_q <  rs2_q);
                    3'b111:  taken_d = (rs1_q >= rs2_q);
                    default: taken_d = 1'b0;
                endcase
            end
            default:   taken_d = 1'b0;
        endcase

        is_jump_d  = (cf_op_q == OP_JAL) || (cf_op_q == OP_JALR);
        misalign_d = taken_d && target_d[1];
    end

    // EVAL strobes are decoded from the state register and latched operands,
    // so they are stable for the whole EVAL cycle.
    assign link_valid_o     = (state_q == S_EVAL) && is_jump_d && !misalign_d;
    assign misalign_exc_o   = (state_q == S_EVAL) && misalign_d;

    assign in_ready_o       = in_ready_q;
    assign redirect_valid_o = redirect_valid_q;
    assign flush_o          = flush_q;
    assign base_sel_o       = base_sel_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign link_data_o      = link_data_q;
    assign exc_pc_o         = exc_pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            base_sel_q       <= 1'b1;
            redirect_pc_q    <= '0;
            link_data_q      <= '0;
            exc_pc_q         <= '0;
            cnt_q            <= '0;
            cf_op_q          <= OP_NOP;
            funct3_q         <= '0;
            pc_q             <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            imm_q            <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        cf_op_q     <= cf_op_i;
                        funct3_q    <= funct3_i;
                        pc_q        <= pc_i;
                        rs1_q       <= rs1_i;
                        rs2_q       <= rs2_i;
                        imm_q       <= imm_i;
                        base_sel_q  <= (cf_op_i != OP_JALR);
                        link_data_q <= pc_i + 32'd4;
                        exc_pc_q    <= pc_i;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (taken_d && !misalign_d) begin
                        redirect_pc_q    <= target_d;
                        redirect_valid_q <= 1'b1;
                        state_q          <= S_REDIRECT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        if (FLUSH_LD == 4'd0) begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q   <= FLUSH_LD;
                            flush_q <= 1'b1;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Leave in the cycle the counter shows 1 so flush lasts
                    // exactly FLUSH_CYCLES cycles.
                    if (cnt_q <= 4'd1) begin
                        flush_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-flow sequencer for the RV32I core's branch/jump path. Accepts one decoded control-flow instruction at a time and drives the PC-vs-rs1 base select for the target adder. It evaluates the branch condition and forms the target. It then issues a redirect to fetch over a valid/ready handshake, followed by a fixed-length pipeline flush, and reports misaligned-target exceptions instead of redirecting.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after an accepted redirect (0 to 15).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: a control-flow instruction is presented.
- `in_ready` out 1: block can accept; high only in IDLE.
- `cf_op` in 2: 00 NOP, 01 BRANCH, 10 JAL, 11 JALR.
- `funct3` in 3: branch condition (BRANCH only).
- `pc`, `rs1`, `rs2`, `imm` in 32 each: instruction PC, operands, sign-extended immediate.
- `base_sel` out 1: 1 = target base is PC (BRANCH/JAL), 0 = base is rs1 (JALR).
- `redirect_valid` out 1: new fetch PC offered.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out 32: target address.
- `link_valid` out 1: one-cycle strobe to write `link_data` to rd.
- `link_data` out 32: latched pc + 4.
- `flush` out 1: squash younger pipeline stages.
- `misalign_exc` out 1: one-cycle strobe for a misaligned taken target.
- `exc_pc` out 32: PC of the faulting instruction.

## Operation
- States: IDLE, EVAL, REDIRECT, FLUSH.
- **IDLE:** `in_ready`=1. When `in_valid`&`in_ready`, latch cf_op, funct3, pc, rs1, rs2, imm and go to EVAL.
- **EVAL:** lasts one cycle; all results are computed from the latched operands.
  - base = `base_sel` ? pc : rs1.
  - target = base + imm, mod 2^32 wrap.
  - For JALR, target[0] is forced to 0.
- **Taken rule:**
  - NOP: never taken.
  - JAL/JALR: always taken.
  - BRANCH by funct3: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. funct3 010/011 are not taken.
- **Misaligned:** taken and target[1] == 1; there is no compressed support.
  - Misaligned: `misalign_exc`=1 and `exc_pc`=pc during EVAL. No link, no redirect. Next state IDLE.
  - Not taken: next state IDLE.
  - Taken: load `redirect_pc`=target and go to REDIRECT.
- **Link:** `link_valid`=1 during EVAL for JAL/JALR only, and only when not misaligned.
- **REDIRECT:** `redirect_valid`=1, with `redirect_pc` held stable until `redirect_ready`.
  - On handshake: if FLUSH_CYCLES=0 go to IDLE, else load the counter with FLUSH_CYCLES and go to FLUSH.
- **FLUSH:** `flush`=1. Counter decrements each cycle; leave for IDLE in the cycle it reaches 1.
- **`base_sel`:** registered at accept. 0 iff the latched cf_op is JALR, else 1. Holds its value until the next accept.
- **Reset:** any state goes to IDLE.
  - `redirect_valid`, `flush`, `link_valid`, `misalign_exc` = 0.
  - `redirect_pc`, `link_data`, `exc_pc` = 0.
  - `base_sel`=1, `in_ready`=1 in the cycle after reset deasserts.
  - A pending redirect is dropped.

## Timing
- Cycle 0: accept.
- Cycle 1: EVAL. Strobes `link_valid`/`misalign_exc` are valid here.
- Cycle 2: earliest `redirect_valid`.
- Minimum occupancy:
  - Not-taken or exception instruction: 2 cycles.
  - Taken instruction: 3 + FLUSH_CYCLES cycles, with `redirect_ready` tied high.
- `in_ready` is low from the cycle after accept until the state returns to IDLE. Back-to-back accepts occur only after a return to IDLE.
- `redirect_valid` never deasserts without a handshake, except on `rst`.
- `redirect_ready` is ignored outside REDIRECT.
- `flush` is asserted for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the handshake.
- `in_valid` held high while `in_ready`=0 has no effect.

## Test plan
- **BEQ taken:** pc=0x100, rs1=rs2=5, imm=0x20.
  - `base_sel`=1, `redirect_pc`=0x120 in cycle 2.
  - `flush` high in cycles 3–4 (FLUSH_CYCLES=2), no `link_valid`.
- **BLT vs BLTU:** rs1=0xFFFFFFFF, rs2=1.
  - BLT is taken.
  - BLTU is not taken: no redirect, `in_ready`=1 in cycle 2.
- **JALR:** rs1=0x2001, imm=0x4, pc=0x40.
  - `base_sel`=0, `redirect_pc`=0x2004.
  - `link_valid`=1 with `link_data`=0x44 in EVAL.
- **Misaligned JAL:** pc=0x10, imm=0x6.
  - `misalign_exc`=1, `exc_pc`=0x10 in EVAL.
  - No `link_valid`, no `redirect_valid`.
- **Backpressure:** taken JAL with `redirect_ready` low for 4 cycles.
  - `redirect_valid` and `redirect_pc` stay stable.
  - `flush` starts the cycle after `redirect_ready` rises.
- **Reset mid-operation:** assert `rst` during REDIRECT and, separately, during FLUSH.
  - Next cycle all outputs are at reset values and `in_ready`=1 after release.
  - A JAL issued after release sequences normally.
